uart_rx: RTL and testbench

Byte-wide UART receiver: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line. It is the receive-side counterpart of the SoC's UART transmitter and sits between the external rx pin and the memory-mapped UART register block. It uses the same CLK_FREQ/BAUD_RATE parameterisation and the same go/acknowledge handshake style, so firmware drives both directions identically.

---
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_rx.sv | 138 +++++++++++++
 tb/tb_uart_rx.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side signal bundle between the rx pin, the UART
// receiver and the register-block consumer that acknowledges bytes.
interface uart_rx_if;
  logic       rx;
  logic       go;
  logic [7:0] data;
  logic       dr;
  logic       ferr;

  // Consumer / pin side: drives the serial line and the acknowledge.
  modport master (
    output rx,
    output go,
    input  data,
    input  dr,
    input  ferr
  );

  // Receiver side.
  modport slave (
    input  rx,
    input  go,
    output data,
    output dr,
    output ferr
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with go/acknowledge handshake.
// All state changes on the falling clock edge; reset is synchronous, active-high.
// BIT_TIME = CLK_FREQ / BAUD_RATE must be at least 4.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 66_000_000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int unsigned BIT_TIME = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF     = BIT_TIME / 2;
  localparam logic [31:0] BIT_M1   = 32'(BIT_TIME - 1);
  localparam logic [31:0] HALF_M1  = 32'(HALF - 1);

  typedef enum logic [6:0] {
    IDLE         = 7'b0000001,
    START        = 7'b0000010,
    DATA         = 7'b0000100,
    STOP         = 7'b0001000,
    WAIT_GO_HIGH = 7'b0010000,
    WAIT_GO_LOW  = 7'b0100000,
    WAIT_LINE    = 7'b1000000
  } state_t;

  state_t      state, state_n;
  logic [31:0] bit_time_counter, counter_n;
  logic [2:0]  bit_count, bit_count_n;
  logic [7:0]  shreg, shreg_n;
  logic        dr_q, dr_n;
  logic        ferr_q, ferr_n;
  logic        rx_meta, rxs;

  // Two-flop synchronizer for the asynchronous rx pin; idles high.
  always_ff @(negedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rxs     <= rx_meta;
    end
  end

  // State, counters, shift register and output flags.
  always_ff @(negedge clk) begin
    if (rst) begin
      state            <= IDLE;
      bit_time_counter <= '0;
      bit_count        <= '0;
      shreg            <= '0;
      dr_q             <= 1'b0;
      ferr_q           <= 1'b0;
    end else begin
      state            <= state_n;
      bit_time_counter <= counter_n;
      bit_count        <= bit_count_n;
      shreg            <= shreg_n;
      dr_q             <= dr_n;
      ferr_q           <= ferr_n;
    end
  end

  // Next-state logic: half-bit delay to centre on the start bit, then one
  // full bit time between samples; ferr defaults low so it is a one-cycle strobe.
  always_comb begin
    state_n     = state;
    counter_n   = bit_time_counter;
    bit_count_n = bit_count;
    shreg_n     = shreg;
    dr_n        = dr_q;
    ferr_n      = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          counter_n = HALF_M1;
          state_n   = START;
        end
      end
      START: begin
        if (bit_time_counter == '0) begin
          if (!rxs) begin
            counter_n   = BIT_M1;
            bit_count_n = '0;
            state_n     = DATA;
          end else begin
            state_n = IDLE;
          end
        end else begin
          counter_n = bit_time_counter - 32'd1;
        end
      end
      DATA: begin
        if (bit_time_counter == '0) begin
          shreg_n     = {rxs, shreg[7:1]};
          counter_n   = BIT_M1;
          bit_count_n = bit_count + 3'd1;
          if (bit_count == 3'd7) state_n = STOP;
        end else begin
          counter_n = bit_time_counter - 32'd1;
        end
      end
      STOP: begin
        if (bit_time_counter == '0) begin
          if (rxs) begin
            dr_n    = 1'b1;
            state_n = WAIT_GO_HIGH;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_LINE;
          end
        end else begin
          counter_n = bit_time_counter - 32'd1;
        end
      end
      WAIT_GO_HIGH: begin
        if (bus.go) begin
          dr_n    = 1'b0;
          state_n = WAIT_GO_LOW;
        end
      end
      WAIT_GO_LOW: begin
        if (!bus.go) state_n = IDLE;
      end
      WAIT_LINE: begin
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.data = shreg;
  assign bus.dr   = dr_q;
  assign bus.ferr = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at BIT_TIME=16, HALF=8.
// DUT acts on falling edges; the bench drives and samples on rising edges.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  int   cyc = 0;
  int   dr_rise_cyc = 0;
  int   ferr_cnt = 0;
  int   ferr_cyc = 0;
  int   dr_high_cnt = 0;
  logic dr_prev = 1'b0;

  uart_rx_if bus ();

  uart_rx #(.CLK_FREQ(16), .BAUD_RATE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Active-edge counter: after falling edge N, cyc == N.
  always @(negedge clk) cyc++;

  // Output monitor, sampled away from the active edge.
  always @(posedge clk) begin
    if (bus.dr && !dr_prev) dr_rise_cyc = cyc;
    dr_prev = bus.dr;
    if (bus.dr) dr_high_cnt++;
    if (bus.ferr) begin
      ferr_cnt++;
      ferr_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Send one frame with ideal 16-cycle bits; t0 is cyc when rx falls.
  // rx is left at stop_bit on return.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t0);
    @(posedge clk);
    bus.rx = 1'b0;
    t0 = cyc;
    repeat (16) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (16) @(posedge clk);
    end
    bus.rx = stop_bit;
    repeat (16) @(posedge clk);
  endtask

  task automatic ack();
    @(posedge clk);
    bus.go = 1'b1;
    @(posedge clk);
    check("ack_dr_low", {31'd0, bus.dr}, 32'd0);
    bus.go = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int base;
    logic [7:0] ff_byte;
    bus.rx = 1'b1;
    bus.go = 1'b0;
    rst    = 1'b1;
    repeat (3) @(posedge clk);
    check("rst_data", {24'd0, bus.data}, 32'h00);
    check("rst_dr",   {31'd0, bus.dr},   32'd0);
    check("rst_ferr", {31'd0, bus.ferr}, 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // Frame 0xA5, go low: dr rises at edge k+152 = t0+155.
    dr_rise_cyc = 0;
    send_frame(8'hA5, 1'b1, t0);
    check("a5_dr_edge", dr_rise_cyc, t0 + 155);
    check("a5_data", {24'd0, bus.data}, 32'hA5);
    check("a5_dr", {31'd0, bus.dr}, 32'd1);
    check("a5_no_ferr", ferr_cnt, 0);

    // One-cycle go pulse, then 0x3C.
    ack();
    dr_rise_cyc = 0;
    send_frame(8'h3C, 1'b1, t0);
    check("3c_dr_edge", dr_rise_cyc, t0 + 155);
    check("3c_data", {24'd0, bus.data}, 32'h3C);
    check("3c_dr", {31'd0, bus.dr}, 32'd1);
    ack();

    // False start: 3 low cycles.
    dr_rise_cyc = 0;
    @(posedge clk);
    bus.rx = 1'b0;
    repeat (3) @(posedge clk);
    bus.rx = 1'b1;
    repeat (24) @(posedge clk);
    check("glitch_dr", {31'd0, bus.dr}, 32'd0);
    check("glitch_no_rise", dr_rise_cyc, 0);
    check("glitch_no_ferr", ferr_cnt, 0);
    send_frame(8'h5A, 1'b1, t0);
    check("5a_dr_edge", dr_rise_cyc, t0 + 155);
    check("5a_data", {24'd0, bus.data}, 32'h5A);
    ack();

    // Framing error, line then held low 40 more cycles.
    base = ferr_cnt;
    dr_rise_cyc = 0;
    send_frame(8'h81, 1'b0, t0);
    check("ferr_edge", ferr_cyc, t0 + 155);
    repeat (40) @(posedge clk);
    check("ferr_once", ferr_cnt - base, 1);
    check("ferr_no_dr", {31'd0, bus.dr}, 32'd0);
    check("ferr_no_rise", dr_rise_cyc, 0);
    bus.rx = 1'b1;
    repeat (5) @(posedge clk);
    send_frame(8'h81, 1'b1, t0);
    check("81_dr_edge", dr_rise_cyc, t0 + 155);
    check("81_data", {24'd0, bus.data}, 32'h81);
    check("81_no_new_ferr", ferr_cnt - base, 1);
    ack();

    // Reset during data bit 4 of 0xFF.
    ff_byte = 8'hFF;
    @(posedge clk);
    bus.rx = 1'b0;
    repeat (16) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rx = ff_byte[i];
      repeat (16) @(posedge clk);
    end
    bus.rx = ff_byte[4];
    repeat (8) @(posedge clk);
    base = ferr_cnt;
    dr_rise_cyc = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    check("midrst_data", {24'd0, bus.data}, 32'h00);
    check("midrst_dr",   {31'd0, bus.dr},   32'd0);
    check("midrst_ferr", {31'd0, bus.ferr}, 32'd0);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    check("midrst_quiet", dr_rise_cyc + (ferr_cnt - base), 0);
    send_frame(8'h00, 1'b1, t0);
    check("00_dr_edge", dr_rise_cyc, t0 + 155);
    check("00_data", {24'd0, bus.data}, 32'h00);
    ack();

    // Unacknowledged 0x11, then 0x22 is lost.
    dr_rise_cyc = 0;
    send_frame(8'h11, 1'b1, t0);
    check("11_dr_edge", dr_rise_cyc, t0 + 155);
    check("11_data", {24'd0, bus.data}, 32'h11);
    send_frame(8'h22, 1'b1, t0);
    check("22_lost_data", {24'd0, bus.data}, 32'h11);
    check("22_lost_dr", {31'd0, bus.dr}, 32'd1);
    ack();
    dr_rise_cyc = 0;
    send_frame(8'h33, 1'b1, t0);
    check("33_dr_edge", dr_rise_cyc, t0 + 155);
    check("33_data", {24'd0, bus.data}, 32'h33);
    ack();

    // go already high when dr rises: dr high exactly one cycle.
    @(posedge clk);
    bus.go = 1'b1;
    base = dr_high_cnt;
    dr_rise_cyc = 0;
    send_frame(8'h44, 1'b1, t0);
    check("44_dr_edge", dr_rise_cyc, t0 + 155);
    check("44_dr_width", dr_high_cnt - base, 1);
    check("44_data", {24'd0, bus.data}, 32'h44);
    bus.go = 1'b0;
    repeat (2) @(posedge clk);
    dr_rise_cyc = 0;
    send_frame(8'h96, 1'b1, t0);
    check("96_dr_edge", dr_rise_cyc, t0 + 155);
    check("96_data", {24'd0, bus.data}, 32'h96);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
